// File: rtl/plab5_mcore_mem_domain_arbiter.sv
// Two-domain (public/secure) arbiter for a shared domain-tagged test memory.
// Optional TDM slot arbitration is enabled by defining PLAB5_MCORE_MEM_ARB_TDM_EN.
module plab5_mcore_mem_domain_arbiter #(
    parameter int p_req_nbits       = 77,
    parameter int p_resp_nbits      = 47,
    parameter int p_max_outstanding = 4,
    parameter int p_slot_cycles     = 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [p_req_nbits-1:0]  memreq_msg,
    output logic                    memreq_domain,

    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [p_resp_nbits-1:0] memresp_msg,
    input  logic                    memresp_domain,

    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,

    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,

    output logic                    domain_err
);

    localparam int DEPTH = p_max_outstanding;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic             domain_err_reg;
    logic             trk_mem [DEPTH];

    logic full;
    logic empty;
    logic head;
    logic grant;
    logic gnt_val;
    logic can_issue;
    logic req_fire;
    logic resp_ok;
    logic resp_match;
    logic resp_mismatch;
    logic resp_fire;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = trk_mem[rd_ptr_reg];

`ifdef PLAB5_MCORE_MEM_ARB_TDM_EN
    localparam int SLOT_W = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;

    logic [SLOT_W-1:0] slot_cnt_reg;
    logic              slot_owner_reg;

    // Grant depends only on time, never on the other domain's activity.
    assign grant = slot_owner_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt_reg   <= '0;
            slot_owner_reg <= 1'b0;
        end else if (slot_cnt_reg == SLOT_W'(p_slot_cycles - 1)) begin
            slot_cnt_reg   <= '0;
            slot_owner_reg <= ~slot_owner_reg;
        end else begin
            slot_cnt_reg   <= slot_cnt_reg + 1'b1;
        end
    end
`else
    logic prio_reg;

    always_comb begin
        if (req0_val && req1_val) grant = prio_reg;
        else                      grant = req1_val;
    end

    // Priority only moves on an accepted request, so a stalled grant is held.
    always_ff @(posedge clk) begin
        if (!reset)        prio_reg <= 1'b0;
        else if (req_fire) prio_reg <= ~grant;
    end
`endif

    always_comb begin
        gnt_val       = grant ? req1_val : req0_val;
        can_issue     = reset && !full && !domain_err_reg;
        memreq_val    = can_issue && gnt_val;
        memreq_msg    = grant ? req1_msg : req0_msg;
        memreq_domain = grant;
        req0_rdy      = can_issue && memreq_rdy && !grant;
        req1_rdy      = can_issue && memreq_rdy && grant;
    end

    // A response is only routed when its tag agrees with the tracked head.
    always_comb begin
        resp_ok       = reset && !domain_err_reg && !empty && memresp_val;
        resp_match    = resp_ok && (memresp_domain == head);
        resp_mismatch = resp_ok && (memresp_domain != head);
        resp0_val     = resp_match && !head;
        resp1_val     = resp_match && head;
        memresp_rdy   = resp_match && (head ? resp1_rdy : resp0_rdy);
        resp0_msg     = memresp_msg;
        resp1_msg     = memresp_msg;
    end

    assign req_fire   = memreq_val && memreq_rdy;
    assign resp_fire  = memresp_val && memresp_rdy;
    assign domain_err = domain_err_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            domain_err_reg <= 1'b0;
        end else begin
            if (req_fire)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (resp_fire)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            if (req_fire && !resp_fire)
                count_reg <= count_reg + 1'b1;
            else if (!req_fire && resp_fire)
                count_reg <= count_reg - 1'b1;
            if (resp_mismatch)
                domain_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            trk_mem[wr_ptr_reg] <= grant;
    end

endmodule

// File: tb/tb_plab5_mcore_mem_domain_arbiter.sv
// Directed self-checking bench for the default (round-robin) arbiter build.
module tb_plab5_mcore_mem_domain_arbiter;

    localparam int RQ = 77;
    localparam int RS = 47;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RQ-1:0] req0_msg, req1_msg, memreq_msg;
    logic          memreq_val, memreq_rdy, memreq_domain;
    logic          memresp_val, memresp_rdy, memresp_domain;
    logic [RS-1:0] memresp_msg, resp0_msg, resp1_msg;
    logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic          domain_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plab5_mcore_mem_domain_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_msg(memreq_msg), .memreq_domain(memreq_domain),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .memresp_msg(memresp_msg), .memresp_domain(memresp_domain),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .domain_err(domain_err)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
        memreq_rdy = 1; memresp_val = 0; memresp_domain = 0; memresp_msg = '0;
        resp0_rdy = 1; resp1_rdy = 1;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, ".vals"}, {memreq_val, resp0_val, resp1_val}, 3'b000);
        chk({tag, ".rdys"}, {req0_rdy, req1_rdy, memresp_rdy}, 3'b000);
    endtask

    // One request cycle: drive both requesters, check the expected grant.
    task automatic req_cycle(input string tag, input logic v0, input logic v1,
                             input logic [RQ-1:0] m0, input logic [RQ-1:0] m1,
                             input logic exp_dom);
        req0_val = v0; req1_val = v1; req0_msg = m0; req1_msg = m1;
        #1;
        chk({tag, ".val"}, memreq_val, 1'b1);
        chk({tag, ".dom"}, memreq_domain, exp_dom);
        chk({tag, ".msg"}, memreq_msg, exp_dom ? m1 : m0);
        chk({tag, ".rdy"}, {req0_rdy, req1_rdy}, exp_dom ? 2'b01 : 2'b10);
        cyc();
    endtask

    // One response cycle: memory returns a tag that matches the head.
    task automatic resp_cycle(input string tag, input logic dom, input logic [RS-1:0] m);
        memresp_val = 1; memresp_domain = dom; memresp_msg = m;
        #1;
        chk({tag, ".vals"}, {resp0_val, resp1_val}, dom ? 2'b01 : 2'b10);
        chk({tag, ".msg"}, dom ? resp1_msg : resp0_msg, m);
        chk({tag, ".mrdy"}, memresp_rdy, 1'b1);
        cyc();
        memresp_val = 0;
    endtask

    initial begin
        reset = 0;
        idle();
        req0_val = 1; req1_val = 1; memresp_val = 1;
        cyc();
        #1;
        outs_zero("rst");
        chk("rst.err", domain_err, 1'b0);
        cyc();
        idle();
        reset = 1;

        // Public requester alone, three back-to-back reads.
        req_cycle("t1.r0", 1, 0, 77'h1_0000_0000, '0, 0);
        req_cycle("t1.r1", 1, 0, 77'h1_0000_0004, '0, 0);
        req_cycle("t1.r2", 1, 0, 77'h1_0000_0008, '0, 0);
        req0_val = 0;
        resp_cycle("t1.p0", 0, 47'h0_AAAA_0001);
        resp_cycle("t1.p1", 0, 47'h0_AAAA_0002);
        resp_cycle("t1.p2", 0, 47'h0_AAAA_0003);
        // Tracker empty: a stray memory response must be ignored.
        memresp_val = 1; memresp_domain = 0;
        #1;
        chk("t1.empty", {resp0_val, resp1_val, memresp_rdy}, 3'b000);
        cyc();
        idle();

        // Fresh reset so round-robin starts at requester 0.
        reset = 0;
        cyc();
        reset = 1;
        req_cycle("t2.g0", 1, 1, 77'h10, 77'h20, 0);
        req_cycle("t2.g1", 1, 1, 77'h11, 77'h21, 1);
        req_cycle("t2.g2", 1, 1, 77'h12, 77'h22, 0);
        req_cycle("t2.g3", 1, 1, 77'h13, 77'h23, 1);
        // Four outstanding: tracker full, no grants.
        #1;
        chk("t3.full", {memreq_val, req0_rdy, req1_rdy}, 3'b000);
        // A pop in this cycle must not unblock a grant until the next cycle.
        memresp_val = 1; memresp_domain = 0; memresp_msg = 47'h100;
        #1;
        chk("t3.pop.vals", {resp0_val, resp1_val, memresp_rdy}, 3'b101);
        chk("t3.pop.blk", {memreq_val, req0_rdy, req1_rdy}, 3'b000);
        cyc();
        memresp_val = 0;
        req_cycle("t3.resume", 1, 1, 77'h14, 77'h24, 0);
        #1;
        chk("t3.refull", {req0_rdy, req1_rdy}, 2'b00);
        req0_val = 0; req1_val = 0;
        resp_cycle("t2.s0", 1, 47'h201);
        resp_cycle("t2.p1", 0, 47'h102);
        resp_cycle("t2.s1", 1, 47'h202);
        resp_cycle("t2.p2", 0, 47'h103);

        // Domain mismatch: head is public, memory answers secure.
        req_cycle("t4.req", 1, 0, 77'h30, '0, 0);
        req0_val = 0;
        memresp_val = 1; memresp_domain = 1; memresp_msg = 47'h300;
        #1;
        chk("t4.iso", {resp0_val, resp1_val, memresp_rdy}, 3'b000);
        chk("t4.err0", domain_err, 1'b0);
        cyc();
        req0_val = 1; req1_val = 1;
        #1;
        chk("t4.err1", domain_err, 1'b1);
        chk("t4.nogrant", {memreq_val, req0_rdy, req1_rdy}, 3'b000);
        chk("t4.stall", {resp0_val, resp1_val, memresp_rdy}, 3'b000);
        cyc();
        #1;
        chk("t4.sticky", domain_err, 1'b1);
        idle();

        // Reset with two requests outstanding and everything valid.
        reset = 0;
        cyc();
        reset = 1;
        req_cycle("t5.g0", 1, 1, 77'h40, 77'h50, 0);
        req_cycle("t5.g1", 1, 1, 77'h41, 77'h51, 1);
        reset = 0;
        memresp_val = 1; memresp_domain = 0;
        #1;
        outs_zero("t5.rst");
        cyc();
        reset = 1;
        #1;
        chk("t5.err", domain_err, 1'b0);
        chk("t5.empty", memresp_rdy, 1'b0);
        memresp_val = 0;
        req_cycle("t5.first", 1, 1, 77'h42, 77'h52, 0);

        idle();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
